// File: rtl/rf_seq_if.sv
// Bundle between the sequencer, the instruction ROM and the reg-file/ALU datapath.
interface rf_seq_if #(
    parameter int PC_W = 8
);
    logic [PC_W-1:0] instr_addr;
    logic [15:0]     instr_data;
    logic [3:0]      RA1;
    logic [3:0]      RA2;
    logic [3:0]      WA;
    logic            write_enable;
    logic [2:0]      alu_op;
    logic [7:0]      imm;
    logic            use_imm;
    logic            rd1_zero;

    modport master (
        output instr_addr, RA1, RA2, WA, write_enable, alu_op, imm, use_imm,
        input  instr_data, rd1_zero
    );

    modport slave (
        input  instr_addr, RA1, RA2, WA, write_enable, alu_op, imm, use_imm,
        output instr_data, rd1_zero
    );
endinterface

// File: rtl/rf_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback controller for the 16x8 register file and ALU.
// One instruction in flight; decoded controls are held through EXEC and WB.
module rf_sequencer #(
    parameter int PC_W     = 8,
    parameter int RESET_PC = 0
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         run_i,
    rf_seq_if.master     bus,
    output logic         busy_o,
    output logic         halted_o,
    output logic         illegal_o
);
    localparam logic [PC_W-1:0] RESET_PC_V = PC_W'(RESET_PC);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_ADDI = 4'h7;
    localparam logic [3:0] OP_BEQZ = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_ADD = 3'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    logic            illegal_q, illegal_d;

    logic [3:0] op, rd, rs1, rs2;
    logic [7:0] ir_imm;
    logic       in_ex;

    assign op     = ir_q[15:12];
    assign rd     = ir_q[11:8];
    assign rs1    = ir_q[7:4];
    assign rs2    = ir_q[3:0];
    assign ir_imm = ir_q[7:0];
    assign in_ex  = (state_q == S_EXEC) || (state_q == S_WB);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC_V;
            ir_q      <= 16'h0000;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE:   if (run_i) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                ir_d    = bus.instr_data;
                pc_d    = pc_q + PC_W'(1);
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LDI, OP_ADDI:
                        state_d = S_WB;
                    // A taken branch replaces the increment made in DECODE.
                    OP_BEQZ: if (bus.rd1_zero) pc_d = PC_W'(ir_imm);
                    OP_JMP:  pc_d = PC_W'(ir_imm);
                    OP_HALT: state_d = S_HALT;
                    OP_NOP:  state_d = S_FETCH;
                    default: illegal_d = 1'b1;
                endcase
            end
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.RA1     = 4'h0;
        bus.RA2     = 4'h0;
        bus.WA      = 4'h0;
        bus.alu_op  = ALU_ADD;
        bus.imm     = 8'h00;
        bus.use_imm = 1'b0;
        if (in_ex) begin
            case (op)
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                    bus.RA1    = rs1;
                    bus.RA2    = rs2;
                    bus.WA     = rd;
                    bus.alu_op = op[2:0] - 3'd1;
                end
                OP_LDI: begin
                    bus.WA      = rd;
                    bus.imm     = ir_imm;
                    bus.use_imm = 1'b1;
                end
                OP_ADDI: begin
                    bus.RA1     = rd;
                    bus.WA      = rd;
                    bus.imm     = ir_imm;
                    bus.use_imm = 1'b1;
                end
                OP_BEQZ: bus.RA1 = rd;
                default: ;
            endcase
        end
    end

    // Reset masks the strobe so a write in flight is dropped on the reset edge.
    assign bus.write_enable = (state_q == S_WB) && !reset_i;
    assign bus.instr_addr   = pc_q;
    assign busy_o           = (state_q == S_FETCH) || (state_q == S_DECODE) || in_ex;
    assign halted_o         = (state_q == S_HALT);
    assign illegal_o        = illegal_q;
endmodule

// File: tb/tb_rf_sequencer.sv
// Bench for rf_sequencer: ROM + 16x8 reg file + ALU around the DUT, with an ISA-level
// timing model feeding a cycle-stamped scoreboard, plus table-driven ALU vectors.
module tb_rf_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic run = 1'b0;
    logic busy, halted, illegal;
    logic clr_rf = 1'b1;

    rf_seq_if #(.PC_W(8)) bus();

    rf_sequencer #(.PC_W(8), .RESET_PC(0)) dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .run_i     (run),
        .bus       (bus),
        .busy_o    (busy),
        .halted_o  (halted),
        .illegal_o (illegal)
    );

    always #5 clk = ~clk;

    logic [15:0] rom [256];
    logic [15:0] rom_q;
    logic [7:0]  rf [16];
    logic [7:0]  opa, opb, res;

    always @(posedge clk) rom_q <= rom[bus.instr_addr];
    assign bus.instr_data = rom_q;
    assign bus.rd1_zero   = (rf[bus.RA1] == 8'h00);

    always_comb begin
        opa = rf[bus.RA1];
        opb = bus.use_imm ? bus.imm : rf[bus.RA2];
        case (bus.alu_op)
            3'd0:    res = opa + opb;
            3'd1:    res = opa - opb;
            3'd2:    res = opa & opb;
            3'd3:    res = opa | opb;
            3'd4:    res = opa ^ opb;
            default: res = 8'h00;
        endcase
    end

    // r0 is hardwired to zero: writes to it are discarded.
    always @(posedge clk) begin
        if (clr_rf) begin
            for (int i = 0; i < 16; i++) rf[i] <= 8'h00;
        end else if (bus.write_enable && bus.WA != 4'h0) begin
            rf[bus.WA] <= res;
        end
    end

    localparam int EV_FETCH = 0;
    localparam int EV_WRITE = 1;
    localparam int EV_HALT  = 2;

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] a;
        logic [7:0] d;
    } ev_t;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    ev_t  sbq[$];
    vec_t vt[7];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic rom_fill();
        for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        clr_rf = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_we", 32'(bus.write_enable), 32'd0);
        check("rst_addr", 32'(bus.instr_addr), 32'd0);
        check("rst_ctl", 32'({bus.RA1, bus.RA2, bus.WA, bus.alu_op, bus.use_imm, bus.imm}), 32'd0);
        reset  = 1'b0;
        clr_rf = 1'b0;
    endtask

    // Instruction-level model: pushes the cycle of every fetch, write and halt.
    task automatic build_expect(output logic ill);
        logic [7:0]  m [16];
        logic [7:0]  pc, npc, r, im;
        logic [15:0] w;
        logic [3:0]  op, rd, s1, s2;
        logic        wr, done;
        int          t;
        ev_t         e;
        for (int i = 0; i < 16; i++) m[i] = 8'h00;
        sbq.delete();
        pc = 8'h00; t = 0; ill = 1'b0; done = 1'b0;
        for (int n = 0; n < 64 && !done; n++) begin
            w = rom[pc];
            op = w[15:12]; rd = w[11:8]; s1 = w[7:4]; s2 = w[3:0]; im = w[7:0];
            e.cyc = t; e.kind = EV_FETCH; e.a = pc; e.d = 8'h00;
            sbq.push_back(e);
            npc = pc + 8'd1; wr = 1'b0; r = 8'h00;
            case (op)
                4'h0: ;
                4'h1: begin r = m[s1] + m[s2]; wr = 1'b1; end
                4'h2: begin r = m[s1] - m[s2]; wr = 1'b1; end
                4'h3: begin r = m[s1] & m[s2]; wr = 1'b1; end
                4'h4: begin r = m[s1] | m[s2]; wr = 1'b1; end
                4'h5: begin r = m[s1] ^ m[s2]; wr = 1'b1; end
                4'h6: begin r = im; wr = 1'b1; end
                4'h7: begin r = m[rd] + im; wr = 1'b1; end
                4'h8: if (m[rd] == 8'h00) npc = im;
                4'h9: npc = im;
                4'hF: done = 1'b1;
                default: ill = 1'b1;
            endcase
            if (done) begin
                e.cyc = t + 3; e.kind = EV_HALT; e.a = 8'h00; e.d = 8'h00;
                sbq.push_back(e);
            end else if (wr) begin
                e.cyc = t + 3; e.kind = EV_WRITE; e.a = {4'h0, rd}; e.d = r;
                sbq.push_back(e);
                if (rd != 4'h0) m[rd] = r;
                t += 4;
            end else begin
                t += 3;
            end
            pc = npc;
        end
    endtask

    task automatic run_prog(input int budget, input int pulse_at);
        logic ill;
        int   cyc;
        bit   exp_we, done;
        ev_t  e;
        do_reset();
        build_expect(ill);
        @(negedge clk); run = 1'b1;
        @(negedge clk); run = 1'b0;
        cyc = 0; done = 1'b0;
        while (!done) begin
            run = (cyc == pulse_at);
            exp_we = 1'b0;
            while (sbq.size() > 0 && sbq[0].cyc == cyc) begin
                e = sbq.pop_front();
                if (e.kind == EV_FETCH) begin
                    check("fetch_addr", 32'(bus.instr_addr), 32'(e.a));
                    check("fetch_busy", 32'(busy), 32'd1);
                    check("fetch_ctl_zero", 32'({bus.RA1, bus.RA2, bus.alu_op, bus.use_imm, bus.imm}), 32'd0);
                end else if (e.kind == EV_WRITE) begin
                    exp_we = 1'b1;
                    check("wb_we", 32'(bus.write_enable), 32'd1);
                    check("wb_wa", 32'(bus.WA), 32'(e.a));
                    check("wb_data", 32'(res), 32'(e.d));
                end else begin
                    check("halted", 32'(halted), 32'd1);
                    check("halt_busy", 32'(busy), 32'd0);
                end
            end
            if (!exp_we) check("stray_we", 32'(bus.write_enable), 32'd0);
            if (sbq.size() == 0) begin
                done = 1'b1;
            end else if (cyc >= budget) begin
                checks++; errors++;
                $display("FAIL timeout cycle=%0d pending_events=%0d required=0", cyc, sbq.size());
                done = 1'b1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        run = 1'b0;
        check("illegal_flag", 32'(illegal), 32'(ill));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{4'h1, 8'h05, 8'h03, 8'h08};
        vt[1] = '{4'h2, 8'h05, 8'h03, 8'h02};
        vt[2] = '{4'h2, 8'h03, 8'h05, 8'hFE};
        vt[3] = '{4'h3, 8'hF0, 8'h3C, 8'h30};
        vt[4] = '{4'h4, 8'hF0, 8'h0F, 8'hFF};
        vt[5] = '{4'h5, 8'hAA, 8'hFF, 8'h55};
        vt[6] = '{4'h1, 8'hFF, 8'h01, 8'h00};

        // LDI r1,a; LDI r2,b; OP r3,r1,r2; HALT. First vector also pulses run mid-execution.
        for (int i = 0; i < 7; i++) begin
            rom_fill();
            rom[0] = {4'h6, 4'h1, vt[i].a};
            rom[1] = {4'h6, 4'h2, vt[i].b};
            rom[2] = {vt[i].op, 4'h3, 4'h1, 4'h2};
            run_prog(80, (i == 0) ? 5 : -1);
            check("alu_r3", 32'(rf[3]), 32'(vt[i].exp));
        end

        // BEQZ taken: fetches 0,1,5.
        rom_fill();
        rom[0] = 16'h6100; rom[1] = 16'h8105; rom[2] = 16'h0000;
        run_prog(80, -1);

        // BEQZ not taken: falls through to 2.
        rom_fill();
        rom[0] = 16'h6107; rom[1] = 16'h8105; rom[5] = 16'h0000;
        run_prog(80, -1);

        // JMP from 0xFF to 0x10.
        rom_fill();
        rom[0] = 16'h90FF; rom[8'hFF] = 16'h9010; rom[8'h10] = 16'hF000;
        run_prog(80, -1);

        // NOP at 0xFF wraps to 0, second BEQZ falls through to HALT.
        rom_fill();
        rom[0] = 16'h81FE; rom[1] = 16'hF000; rom[8'hFE] = 16'h6101; rom[8'hFF] = 16'h0000;
        run_prog(80, -1);
        check("wrap_r1", 32'(rf[1]), 32'h01);

        // Undefined opcode: illegal sticks, no write, continues at 1.
        rom_fill();
        rom[0] = 16'hB000; rom[1] = 16'h6209; rom[2] = 16'hF000;
        run_prog(80, -1);
        check("illegal_sticky", 32'(illegal), 32'd1);
        check("illegal_r2", 32'(rf[2]), 32'h09);
        do_reset();

        // Writes to r0 still strobe; r0 reads back 0; ADDI.
        rom_fill();
        rom[0] = 16'h60FF; rom[1] = 16'h1500; rom[2] = 16'h750A; rom[3] = 16'hF000;
        run_prog(80, -1);
        check("r0_reads_zero", 32'(rf[0]), 32'h00);
        check("addi_r5", 32'(rf[5]), 32'h0A);

        // Reset asserted during WB of LDI r4.
        begin
            int k;
            rom_fill();
            rom[0] = 16'h6433;
            do_reset();
            @(negedge clk); run = 1'b1;
            @(negedge clk); run = 1'b0;
            k = 0;
            while (!bus.write_enable && k < 10) begin
                @(negedge clk);
                k++;
            end
            check("wb_reached", 32'(bus.write_enable), 32'd1);
            reset = 1'b1;
            #1;
            check("we_masked", 32'(bus.write_enable), 32'd0);
            @(negedge clk);
            check("rwb_busy", 32'(busy), 32'd0);
            check("rwb_we", 32'(bus.write_enable), 32'd0);
            check("rwb_addr", 32'(bus.instr_addr), 32'd0);
            check("rwb_r4", 32'(rf[4]), 32'h00);
            reset = 1'b0;
            @(negedge clk);
            check("rwb_idle", 32'(busy), 32'd0);
            check("rwb_we2", 32'(bus.write_enable), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
